// File: rtl/mux_16to1_scan_ctrl_if.sv
// Handshake and data bundle between a scan controller and mux_16to1_scan_ctrl.
// MUX_SCAN_CONT_EN adds the cont request line.
interface mux_16to1_scan_ctrl_if #(
   parameter int DWELL_W = 8
);
   logic               start;
   logic [DWELL_W-1:0] dwell;
   logic [15:0]        ch_mask;
   logic               mux_out;
   logic [3:0]         sel;
   logic [15:0]        capture;
   logic               busy;
   logic               done;
`ifdef MUX_SCAN_CONT_EN
   logic               cont;
`endif

   modport master (
`ifdef MUX_SCAN_CONT_EN
      output cont,
`endif
      output start, dwell, ch_mask, mux_out,
      input  sel, capture, busy, done
   );

   modport slave (
`ifdef MUX_SCAN_CONT_EN
      input  cont,
`endif
      input  start, dwell, ch_mask, mux_out,
      output sel, capture, busy, done
   );
endinterface

// File: rtl/mux_16to1_scan_ctrl.sv
// Select sequencer for a 16:1 bit mux: settles, samples and captures each enabled channel.
// Optional MUX_SCAN_CONT_EN: cont restarts the scan straight from DONE.
module mux_16to1_scan_ctrl #(
   parameter int DWELL_W = 8
) (
   input logic                   clk,
   input logic                   reset,
   mux_16to1_scan_ctrl_if.slave  bus
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_SETTLE,
      S_SAMPLE,
      S_DONE
   } state_t;

   state_t             state_q, state_d;
   logic [DWELL_W-1:0] cnt_q, cnt_d;
   logic [DWELL_W-1:0] dwell_q, dwell_d;
   logic [15:0]        mask_q, mask_d;
   logic [15:0]        cap_q, cap_d;
   logic [3:0]         sel_q, sel_d;

   logic [3:0]         first_in;
   logic               nxt_found;
   logic [3:0]         nxt_ch;
`ifdef MUX_SCAN_CONT_EN
   logic [3:0]         first_q;
`endif

   // Lowest set bit; scanning downward lets the last hit win.
   function automatic logic [3:0] lowest(input logic [15:0] m);
      logic [3:0] r;
      r = '0;
      for (int i = 15; i >= 0; i--) begin
         if (m[i]) r = 4'(i);
      end
      return r;
   endfunction

   always_comb begin
      first_in = lowest(bus.ch_mask);
   end

`ifdef MUX_SCAN_CONT_EN
   always_comb begin
      first_q = lowest(mask_q);
   end
`endif

   // Next enabled channel strictly above the current select.
   always_comb begin
      nxt_found = 1'b0;
      nxt_ch    = sel_q;
      for (int i = 15; i >= 0; i--) begin
         if (mask_q[i] && (4'(i) > sel_q)) begin
            nxt_found = 1'b1;
            nxt_ch    = 4'(i);
         end
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      dwell_d = dwell_q;
      mask_d  = mask_q;
      cap_d   = cap_q;
      sel_d   = sel_q;
      unique case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               dwell_d = bus.dwell;
               mask_d  = bus.ch_mask;
               cap_d   = '0;
               if (bus.ch_mask == '0) begin
                  state_d = S_DONE;
               end else begin
                  sel_d   = first_in;
                  cnt_d   = bus.dwell;
                  state_d = S_SETTLE;
               end
            end
         end
         S_SETTLE: begin
            if (cnt_q == '0) begin
               state_d = S_SAMPLE;
            end else begin
               cnt_d = cnt_q - DWELL_W'(1);
            end
         end
         S_SAMPLE: begin
            cap_d[sel_q] = bus.mux_out;
            if (nxt_found) begin
               sel_d   = nxt_ch;
               cnt_d   = dwell_q;
               state_d = S_SETTLE;
            end else begin
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
`ifdef MUX_SCAN_CONT_EN
            // Capture is kept; each bit is refreshed as it is re-sampled.
            if (bus.cont && (mask_q != '0)) begin
               sel_d   = first_q;
               cnt_d   = dwell_q;
               state_d = S_SETTLE;
            end
`endif
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         dwell_q <= '0;
         mask_q  <= '0;
         cap_q   <= '0;
         sel_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         dwell_q <= dwell_d;
         mask_q  <= mask_d;
         cap_q   <= cap_d;
         sel_q   <= sel_d;
      end
   end

   always_comb begin
      bus.sel     = sel_q;
      bus.capture = cap_q;
      bus.busy    = (state_q == S_SETTLE) || (state_q == S_SAMPLE);
      bus.done    = (state_q == S_DONE);
   end

endmodule

// File: tb/tb_mux_16to1_scan_ctrl.sv
// Randomized self-checking bench for mux_16to1_scan_ctrl against a trace model.
// Continuous-mode scenario is built only with MUX_SCAN_CONT_EN.
module tb_mux_16to1_scan_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic [15:0] pat;
   int          tests_run = 0;
   int          tests_failed = 0;

   logic [3:0]   m_sel;
   logic [255:0] o_sel, e_sel;
   logic [63:0]  o_busy, e_busy, o_done, e_done;
   logic [15:0]  e_cap;

   mux_16to1_scan_ctrl_if #(.DWELL_W(8)) bus();

   mux_16to1_scan_ctrl #(.DWELL_W(8)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   assign bus.mux_out = pat[bus.sel];

   // Expected per-cycle trace, index j = j-th cycle after start is taken.
   task automatic model(input logic [15:0] m, input int dw, input int n);
      int         ch[$];
      int         per;
      int         len;
      logic [3:0] last;
      e_sel = '0; e_busy = '0; e_done = '0;
      for (int i = 0; i < 16; i++) if (m[i]) ch.push_back(i);
      per  = dw + 2;
      len  = ch.size() * per;
      last = m_sel;
      if (ch.size() > 0) last = 4'(ch[ch.size()-1]);
      for (int j = 0; j < n; j++) begin
         if (j < len) begin
            e_sel[j*4 +: 4] = 4'(ch[j / per]);
            e_busy[j]       = 1'b1;
         end else begin
            e_sel[j*4 +: 4] = last;
            e_done[j]       = (j == len);
         end
      end
      e_cap = m & pat;
      m_sel = last;
   endtask

   task automatic launch(input logic [15:0] m, input int dw);
      @(posedge clk); #1;
      bus.ch_mask = m;
      bus.dwell   = 8'(dw);
      bus.start   = 1'b1;
      @(posedge clk); #1;
      bus.start   = 1'b0;
   endtask

   task automatic record(input int n, input bit poke);
      o_sel = '0; o_busy = '0; o_done = '0;
      for (int j = 0; j < n; j++) begin
         @(negedge clk);
         o_sel[j*4 +: 4] = bus.sel;
         o_busy[j]       = bus.busy;
         o_done[j]       = bus.done;
         if (poke) begin
            bus.start = (j == 3) || (j == 7);
            if (j == 5) begin
               bus.ch_mask = '0;
               bus.dwell   = 8'd0;
            end
         end
      end
      bus.start = 1'b0;
   endtask

   task automatic test_reset;
      reset = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      tests_run++;
      if ({bus.sel, bus.capture, bus.busy, bus.done} !== 22'd0) begin
         tests_failed++;
         $display("FAIL por_outputs got=%h exp=0",
                  {bus.sel, bus.capture, bus.busy, bus.done});
      end
      reset = 1'b0;
      m_sel = 4'd0;
      pat   = 16'hFFFF;
      launch(16'hFFFF, 3);
      record(12, 1'b0);
      reset = 1'b1;
      @(posedge clk);
      @(negedge clk);
      tests_run++;
      if (bus.sel !== 4'd0) begin
         tests_failed++;
         $display("FAIL rst_sel got=%h exp=0", bus.sel);
      end
      tests_run++;
      if (bus.capture !== 16'd0) begin
         tests_failed++;
         $display("FAIL rst_capture got=%h exp=0", bus.capture);
      end
      tests_run++;
      if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
         tests_failed++;
         $display("FAIL rst_busy_done got=%b%b exp=00", bus.busy, bus.done);
      end
      @(posedge clk);
      #1 reset = 1'b0;
      m_sel = 4'd0;
      record(40, 1'b0);
      tests_run++;
      if (o_done !== 64'd0 || o_busy !== 64'd0) begin
         tests_failed++;
         $display("FAIL rst_no_done got=%h/%h exp=0", o_done, o_busy);
      end
      tests_run++;
      if (o_sel !== 256'd0) begin
         tests_failed++;
         $display("FAIL rst_sel_hold got=%h exp=0", o_sel);
      end
   endtask

   task automatic test_full_scan;
      pat = 16'hA5C3;
      model(16'hFFFF, 0, 36);
      launch(16'hFFFF, 0);
      record(36, 1'b0);
      tests_run++;
      if (o_sel !== e_sel) begin
         tests_failed++;
         $display("FAIL full_sel got=%h exp=%h", o_sel, e_sel);
      end
      tests_run++;
      if (o_busy !== e_busy) begin
         tests_failed++;
         $display("FAIL full_busy got=%h exp=%h", o_busy, e_busy);
      end
      tests_run++;
      if (o_done !== e_done) begin
         tests_failed++;
         $display("FAIL full_done got=%h exp=%h", o_done, e_done);
      end
      tests_run++;
      if (bus.capture !== 16'hA5C3) begin
         tests_failed++;
         $display("FAIL full_capture got=%h exp=a5c3", bus.capture);
      end
   endtask

   task automatic test_empty_mask;
      model(16'h0000, 2, 6);
      launch(16'h0000, 2);
      record(6, 1'b0);
      tests_run++;
      if (o_sel !== e_sel) begin
         tests_failed++;
         $display("FAIL empty_sel got=%h exp=%h", o_sel, e_sel);
      end
      tests_run++;
      if (o_busy !== 64'd0) begin
         tests_failed++;
         $display("FAIL empty_busy got=%h exp=0", o_busy);
      end
      tests_run++;
      if (o_done !== e_done) begin
         tests_failed++;
         $display("FAIL empty_done got=%h exp=%h", o_done, e_done);
      end
      tests_run++;
      if (bus.capture !== 16'd0) begin
         tests_failed++;
         $display("FAIL empty_capture got=%h exp=0", bus.capture);
      end
   endtask

   task automatic test_sparse_mask;
      pat = 16'hFFFF;
      model(16'h8101, 2, 20);
      launch(16'h8101, 2);
      record(20, 1'b0);
      tests_run++;
      if (o_sel !== e_sel) begin
         tests_failed++;
         $display("FAIL sparse_sel got=%h exp=%h", o_sel, e_sel);
      end
      tests_run++;
      if (o_busy !== e_busy) begin
         tests_failed++;
         $display("FAIL sparse_busy got=%h exp=%h", o_busy, e_busy);
      end
      tests_run++;
      if (o_done !== e_done) begin
         tests_failed++;
         $display("FAIL sparse_done got=%h exp=%h", o_done, e_done);
      end
      pat = 16'h0000;
      repeat (5) @(negedge clk);
      tests_run++;
      if (bus.capture !== 16'h8101) begin
         tests_failed++;
         $display("FAIL sparse_capture_hold got=%h exp=8101", bus.capture);
      end
   endtask

   task automatic test_ignored_start;
      pat = 16'($urandom);
      model(16'hFF0F, 1, 40);
      launch(16'hFF0F, 1);
      record(40, 1'b1);
      tests_run++;
      if (o_sel !== e_sel) begin
         tests_failed++;
         $display("FAIL ign_sel got=%h exp=%h", o_sel, e_sel);
      end
      tests_run++;
      if (o_busy !== e_busy) begin
         tests_failed++;
         $display("FAIL ign_busy got=%h exp=%h", o_busy, e_busy);
      end
      tests_run++;
      if (o_done !== e_done) begin
         tests_failed++;
         $display("FAIL ign_done got=%h exp=%h", o_done, e_done);
      end
      tests_run++;
      if (bus.capture !== e_cap) begin
         tests_failed++;
         $display("FAIL ign_capture got=%h exp=%h", bus.capture, e_cap);
      end
   endtask

   task automatic test_random_scans;
      logic [15:0] m;
      int          dw;
      int          n;
      for (int k = 0; k < 6; k++) begin
         m   = 16'($urandom);
         dw  = $urandom_range(0, 1);
         pat = 16'($urandom);
         n   = $countones(m) * (dw + 2) + 4;
         model(m, dw, n);
         launch(m, dw);
         record(n, 1'b0);
         tests_run++;
         if (o_sel !== e_sel || o_busy !== e_busy || o_done !== e_done) begin
            tests_failed++;
            $display("FAIL rand_trace m=%h dw=%0d sel=%h exp=%h done=%h exp=%h",
                     m, dw, o_sel, e_sel, o_done, e_done);
         end
         tests_run++;
         if (bus.capture !== e_cap) begin
            tests_failed++;
            $display("FAIL rand_capture m=%h got=%h exp=%h",
                     m, bus.capture, e_cap);
         end
      end
   endtask

`ifdef MUX_SCAN_CONT_EN
   task automatic test_continuous;
      int         kk;
      logic [3:0] s;
      pat = 16'($urandom);
      bus.cont = 1'b1;
      e_sel = '0; e_busy = '0; e_done = '0;
      for (int j = 0; j < 30; j++) begin
         kk = j % 7;
         s  = (kk < 3) ? 4'd0 : 4'd1;
         e_sel[j*4 +: 4] = s;
         e_busy[j]       = (kk < 6);
         e_done[j]       = (kk == 6);
      end
      launch(16'h0003, 1);
      record(30, 1'b0);
      tests_run++;
      if (o_sel !== e_sel || o_busy !== e_busy || o_done !== e_done) begin
         tests_failed++;
         $display("FAIL cont_loop sel=%h exp=%h done=%h exp=%h",
                  o_sel, e_sel, o_done, e_done);
      end
      bus.cont = 1'b0;
      e_sel = '0; e_busy = '0; e_done = '0;
      for (int i = 0; i < 12; i++) begin
         kk = (30 + i) % 7;
         e_sel[i*4 +: 4] = (i <= 4 && kk < 3) ? 4'd0 : 4'd1;
         e_busy[i]       = (i < 4);
         e_done[i]       = (i == 4);
      end
      record(12, 1'b0);
      tests_run++;
      if (o_sel !== e_sel || o_busy !== e_busy || o_done !== e_done) begin
         tests_failed++;
         $display("FAIL cont_stop sel=%h exp=%h done=%h exp=%h",
                  o_sel, e_sel, o_done, e_done);
      end
      tests_run++;
      if (bus.capture !== (pat & 16'h0003)) begin
         tests_failed++;
         $display("FAIL cont_capture got=%h exp=%h",
                  bus.capture, pat & 16'h0003);
      end
      m_sel = 4'd1;
   endtask
`endif

   initial begin
      reset       = 1'b1;
      pat         = 16'h0000;
      bus.start   = 1'b0;
      bus.ch_mask = 16'h0000;
      bus.dwell   = 8'd0;
`ifdef MUX_SCAN_CONT_EN
      bus.cont    = 1'b0;
`endif
      test_reset();
      test_full_scan();
      test_empty_mask();
      test_sparse_mask();
      test_ignored_start();
      test_random_scans();
`ifdef MUX_SCAN_CONT_EN
      test_continuous();
`endif
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/mux_16to1_scan_ctrl.md
Name: mux_16to1_scan_ctrl

Overview:
- Upstream select sequencer for the 16:1 bit mux (mux_16to1).
- Drives the mux select through the enabled channels in ascending order, waits a programmable settle time per channel, and samples the mux output into a 16-bit capture word.
- Start/busy/done handshake lets a controller request one full scan and collect all 16 channel bits.

Parameters:
DWELL_W, 8, width of the per-channel settle counter / dwell input

Ports:
clk  input  1  system clock; all logic is on the rising edge
reset  input  1  synchronous, active-high reset
start  input  1  scan request; sampled only in IDLE
dwell  input  DWELL_W  settle cycles per channel; latched on accepted start
ch_mask  input  16  channel enable bits (bit i = channel i); latched on accepted start
mux_out  input  1  Out of the downstream 16:1 mux
sel  output  4  select driven to the mux
capture  output  16  sampled bits; bit i = mux_out seen while sel==i
busy  output  1  high while a scan is in progress
done  output  1  one-cycle pulse when a scan completes

Behaviour:
- Interface is fixed: one clock, clk; reset is synchronous and active-high on reset.
- Reset values: sel=0, capture=0, busy=0, done=0, state=IDLE, counter=0.
- Reset asserted mid-scan aborts the scan immediately. No done pulse is produced, and all outputs return to their reset values on the next edge.
- FSM has four states: IDLE, SETTLE, SAMPLE, DONE.
- IDLE: busy=0, done=0, sel holds its last value.
  - On start=1 at edge T: latch dwell and ch_mask, and clear capture to 0 at T+1.
  - If the latched mask is 0: go to DONE at T+1.
  - Otherwise: at T+1 sel = lowest enabled channel, counter = dwell, state = SETTLE, busy=1.
- SETTLE: if counter==0, go to SAMPLE; otherwise decrement. SETTLE therefore lasts dwell+1 cycles. dwell=0 is legal and gives 1 cycle.
- SAMPLE (one cycle):
  - capture[sel] <= mux_out.
  - If a higher enabled channel exists: sel = next enabled channel, counter = dwell, go to SETTLE.
  - Otherwise go to DONE.
- DONE (one cycle): done=1, busy=0. Next state is IDLE.
- Latency: with N enabled channels and start accepted at edge T, done is high in the cycle after edge T+1+N*(dwell+2). For N=0, done is high after T+1.
- Masked channels are never selected; their capture bits stay 0.
- Channel 15 is the last channel. There is no wrap-around within a scan.
- start while busy or in DONE is ignored (not queued).
- dwell and ch_mask changes during a scan have no effect; only the latched copies are used.
- capture holds its value after done until the next accepted start or reset.
- Next-channel search is combinational priority logic over latched_mask bits above the current sel.

Optional Feature:
- Macro: MUX_SCAN_CONT_EN.
- When defined:
  - Adds input port cont (1 bit).
  - If cont=1 during the DONE cycle, the block pulses done normally and then goes directly to SETTLE on the lowest enabled channel with the latched dwell/mask. It does not pass through IDLE.
  - capture is not cleared; each bit is overwritten as its channel is re-sampled.
  - busy=0 only during the DONE cycle.
  - An all-zero latched mask never restarts; the block returns to IDLE.
- When not defined: the cont port is absent and DONE always returns to IDLE.

Test Plan:
- Reset: assert reset for 2 cycles mid-scan (mask=16'hFFFF, dwell=3) -> sel=0, capture=0, busy=0, done=0 on the next edge; no done pulse follows.
- Full scan: mask=16'hFFFF, dwell=0, mux model Out = pattern[sel] with pattern=16'hA5C3, start at T -> sel steps 0..15 every 2 cycles, done pulse after T+33, capture=16'hA5C3.
- Sparse mask: mask=16'h8101, dwell=2, pattern=16'hFFFF -> sel visits only 0, 8, 15, each held 4 cycles; done after T+13; capture=16'h8101.
- Empty mask: mask=16'h0000 -> busy never asserts, done pulse after T+1, capture=0, sel unchanged.
- Ignored start: pulse start at cycles 3 and 7 of a running scan, and change ch_mask to 0 mid-scan -> scan completes with its original timing and capture; exactly one done.
- Continuous mode (MUX_SCAN_CONT_EN, cont=1): mask=16'h0003, dwell=1 -> done pulses every 7 cycles; sel alternates 0,1 indefinitely. Dropping cont makes the block return to IDLE after the next done.
